// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event decoder:
// parser states, prefix and modifier scancodes, and the queued event record.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bit positions of each physically distinct modifier key in the held vector.
    localparam int HK_LSHIFT = 0;
    localparam int HK_RSHIFT = 1;
    localparam int HK_LCTRL  = 2;
    localparam int HK_RCTRL  = 3;
    localparam int HK_LALT   = 4;
    localparam int HK_RALT   = 5;
    localparam int HK_CAPS   = 6;
    localparam int HK_COUNT  = 7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;
    } kbd_event_t;

    // Keyboard status/ack bytes that never form part of a key sequence.
    function automatic logic is_filler_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hE1) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Small synchronous FIFO holding decoded key events; a push on a full FIFO is
// accepted only when a pop happens on the same edge, otherwise it is reported as dropped.
module kbd_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign rdata   = mem[rd_ptr];

    // Storage has no reset; the read side is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 scancode-set-2 parser turning E0/F0 sequences into queued make/break events
// with modifier state. Optional autorepeat suppression: define KBD_TYPEMATIC_FILTER_EN.
module kbd_event_decoder
    import kbd_pkg::*;
#(
    parameter int EV_FIFO_DEPTH = 4,
    parameter int MOD_TRACK     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [3:0] ev_mods,
    output logic       overflow
);

    localparam int EW = $bits(kbd_event_t);

    parse_state_t        state;
    parse_state_t        state_next;
    logic                capture;
    logic                emit;
    logic                emit_ext;
    logic                emit_brk;
    logic                accept;
    logic [HK_COUNT-1:0] held;
    logic [HK_COUNT-1:0] held_next;
    logic                caps_on;
    logic                caps_next;
    logic [3:0]          mods_post;
    logic [3:0]          event_mods;
    kbd_event_t          push_ev;
    kbd_event_t          head_ev;
    logic [EW-1:0]       head_raw;
    logic                fifo_empty;
    logic                fifo_dropped;
    logic                pop;

    // A byte is taken only while the pop strobe is idle, so at most one byte per two cycles.
    assign capture = ready && nextdata_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            nextdata_n <= 1'b1;
        end else begin
            nextdata_n <= !capture;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        if (capture) begin
            case (state)
                IDLE: begin
                    if (data == PFX_E0) begin
                        state_next = EXT;
                    end else if (data == PFX_F0) begin
                        state_next = BRK;
                    end else if (!is_filler_byte(data)) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (data == PFX_F0) begin
                        state_next = EXT_BRK;
                    end else if (data != PFX_E0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    emit       = 1'b1;
                    emit_brk   = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    emit       = 1'b1;
                    emit_ext   = 1'b1;
                    emit_brk   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic       last_valid;
    logic       last_ext;
    logic [7:0] last_code;
    logic       same_as_last;

    assign same_as_last = last_valid && (last_ext == emit_ext) && (last_code == data);
    assign accept       = emit && !(same_as_last && !emit_brk);

    // Remembers the most recent make; its own break forgets it, any new make replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_valid <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= '0;
        end else if (emit && !emit_brk && !same_as_last) begin
            last_valid <= 1'b1;
            last_ext   <= emit_ext;
            last_code  <= data;
        end else if (emit && emit_brk && same_as_last) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign accept = emit;
`endif

    // Left and right copies of a modifier are held separately so releasing one keeps the other active.
    always_comb begin
        held_next = held;
        caps_next = caps_on;
        if (accept) begin
            case ({emit_ext, data})
                {1'b0, SC_LSHIFT}: held_next[HK_LSHIFT] = !emit_brk;
                {1'b0, SC_RSHIFT}: held_next[HK_RSHIFT] = !emit_brk;
                {1'b0, SC_CTRL}:   held_next[HK_LCTRL]  = !emit_brk;
                {1'b1, SC_CTRL}:   held_next[HK_RCTRL]  = !emit_brk;
                {1'b0, SC_ALT}:    held_next[HK_LALT]   = !emit_brk;
                {1'b1, SC_ALT}:    held_next[HK_RALT]   = !emit_brk;
                {1'b0, SC_CAPS}: begin
                    if (!emit_brk && !held[HK_CAPS]) begin
                        caps_next = !caps_on;
                    end
                    held_next[HK_CAPS] = !emit_brk;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held    <= '0;
            caps_on <= 1'b0;
        end else begin
            held    <= held_next;
            caps_on <= caps_next;
        end
    end

    assign mods_post = {caps_next,
                        held_next[HK_LALT]   | held_next[HK_RALT],
                        held_next[HK_LCTRL]  | held_next[HK_RCTRL],
                        held_next[HK_LSHIFT] | held_next[HK_RSHIFT]};

    assign event_mods = (MOD_TRACK != 0) ? mods_post : 4'h0;

    always_comb begin
        push_ev.code = data;
        push_ev.ext  = emit_ext;
        push_ev.brk  = emit_brk;
        push_ev.mods = event_mods;
    end

    assign pop = ev_valid && ev_ready;

    kbd_event_fifo #(
        .DEPTH (EV_FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .wdata   (push_ev),
        .pop     (pop),
        .rdata   (head_raw),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_dropped) begin
            overflow <= 1'b1;
        end
    end

    // Head fields read as zero while the FIFO is empty so uninitialised storage never shows.
    assign ev_valid = !fifo_empty;
    assign head_ev  = ev_valid ? kbd_event_t'(head_raw) : '0;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_break = head_ev.brk;
    assign ev_mods  = head_ev.mods;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Self-checking bench for kbd_event_decoder: directed key sequences plus random byte
// streams compared every cycle against a key-set / event-queue reference model.
module tb_kbd_event_decoder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       ready;
    logic [7:0] data;
    logic       nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [3:0] ev_mods;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    bit rand_ready  = 0;
    bit ready_force = 1;
    bit chk_en      = 0;

    // Reference model state
    logic [13:0] mq[$];
    bit          m_ovf;
    bit          m_ndn;
    bit          ext_pend;
    bit          brk_pend;
    bit          held[512];
    bit          caps;
    bit          last_valid;
    logic [8:0]  last_key;

    logic [13:0] evlog[$];
    logic [13:0] expq[$];

    kbd_event_decoder #(
        .EV_FIFO_DEPTH (DEPTH),
        .MOD_TRACK     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nextdata_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_mods    (ev_mods),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [13:0] mkEv(input logic [7:0] c, input logic x,
                                         input logic b, input logic [3:0] m);
        return {c, x, b, m};
    endfunction

    function automatic bit isNoise(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    // Interprets one byte: pending prefixes, then the set of held keys decides the modifiers.
    task automatic modelByte(input logic [7:0] b, output bit have, output logic [13:0] e);
        bit         brk;
        logic [8:0] key;
        have = 0;
        brk  = 0;
        key  = '0;
        e    = '0;
        if (brk_pend) begin
            brk = 1; key = {ext_pend, b}; have = 1;
            ext_pend = 0; brk_pend = 0;
        end else if (b == 8'hF0) begin
            brk_pend = 1;
        end else if (b == 8'hE0) begin
            ext_pend = 1;
        end else if (ext_pend || !isNoise(b)) begin
            key = {ext_pend, b}; have = 1;
            ext_pend = 0;
        end
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (have) begin
            if (!brk && last_valid && last_key == key) begin
                have = 0;
            end else if (!brk) begin
                last_valid = 1; last_key = key;
            end else if (last_valid && last_key == key) begin
                last_valid = 0;
            end
        end
`endif
        if (have) begin
            if (!brk && key == 9'h058 && !held[9'h058]) caps = !caps;
            held[key] = !brk;
            e = {key[7:0], key[8], brk, caps,
                 held[9'h011] | held[9'h111],
                 held[9'h014] | held[9'h114],
                 held[9'h012] | held[9'h059]};
        end
    endtask

    always @(posedge clk) begin
        bit          do_pop;
        bit          cap;
        bit          have;
        logic [13:0] e;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_ndn = 1; ext_pend = 0; brk_pend = 0;
            caps = 0; last_valid = 0; last_key = '0;
            for (int k = 0; k < 512; k++) held[k] = 0;
        end else begin
            do_pop = (mq.size() != 0) && ev_ready;
            cap    = ready && m_ndn;
            m_ndn  = !cap;
            if (do_pop) void'(mq.pop_front());
            if (cap) begin
                modelByte(data, have, e);
                if (have) begin
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else m_ovf = 1;
                end
            end
        end
    end

    function automatic logic [31:0] observedVector();
        return {15'b0, ev_valid, ev_code, ev_ext, ev_break, ev_mods, overflow, nextdata_n};
    endfunction

    function automatic logic [31:0] expectedVector();
        logic [13:0] h;
        h = (mq.size() != 0) ? mq[0] : 14'h0;
        return {15'b0, mq.size() != 0, h, m_ovf, m_ndn};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("outputs", observedVector(), expectedVector());
            if (ev_valid && ev_ready) evlog.push_back({ev_code, ev_ext, ev_break, ev_mods});
        end
    end

    // Consumer handshake changes shortly after each rising edge and stays stable across the next one.
    initial begin
        ev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) ev_ready = ($urandom_range(0, 2) != 0);
            else            ev_ready = ready_force;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        ready = 1'b1;
        data  = b;
        @(negedge clk);
        @(negedge clk);
        if (gap > 0) begin
            ready = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (ev_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drained"}, {31'b0, ev_valid}, 32'h0);
    endtask

    task automatic checkEvents(input string tag, input int base);
        logic [31:0] obs;
        checkOutput({tag, "_count"}, evlog.size() - base, expq.size());
        foreach (expq[i]) begin
            obs = (base + i < evlog.size()) ? {18'b0, evlog[base + i]} : 32'hFFFFFFFF;
            checkOutput($sformatf("%s_ev%0d", tag, i), obs, {18'b0, expq[i]});
        end
    endtask

    function automatic logic [7:0] pickByte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) return 8'hE0;
        if (r < 30) return 8'hF0;
        if (r < 50) begin
            case ($urandom_range(0, 4))
                0:       return 8'h12;
                1:       return 8'h59;
                2:       return 8'h14;
                3:       return 8'h11;
                default: return 8'h58;
            endcase
        end
        if (r < 55) begin
            case ($urandom_range(0, 2))
                0:       return 8'hAA;
                1:       return 8'h00;
                default: return 8'hFA;
            endcase
        end
        if (r < 65) return 8'h1C;
        return 8'($urandom_range(1, 8'h83));
    endfunction

    initial begin
        int base;
        reset = 1'b1;
        ready = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", observedVector(), 32'h1);
        reset  = 1'b0;
        chk_en = 1;
        @(negedge clk);

        // Plain make then break
        base = evlog.size();
        applyStimulus(8'h1C, 1); applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 2);
        waitDrain("s_make_break");
        expq.delete();
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1C, 0, 1, 4'h0));
        checkEvents("s_make_break", base);

        // Shift held across another key
        doReset();
        base = evlog.size();
        applyStimulus(8'h12, 0); applyStimulus(8'h1C, 0);
        applyStimulus(8'hF0, 0); applyStimulus(8'h12, 2);
        waitDrain("s_shift");
        expq.delete();
        expq.push_back(mkEv(8'h12, 0, 0, 4'h1));
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h1));
        expq.push_back(mkEv(8'h12, 0, 1, 4'h0));
        checkEvents("s_shift", base);

        // Extended make and break
        doReset();
        base = evlog.size();
        applyStimulus(8'hE0, 0); applyStimulus(8'h75, 1);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 2);
        waitDrain("s_ext");
        expq.delete();
        expq.push_back(mkEv(8'h75, 1, 0, 4'h0));
        expq.push_back(mkEv(8'h75, 1, 1, 4'h0));
        checkEvents("s_ext", base);

        // Fill past capacity with the consumer stalled
        doReset();
        ready_force = 0;
        repeat (2) @(negedge clk);
        base = evlog.size();
        applyStimulus(8'h1C, 0); applyStimulus(8'h1B, 0); applyStimulus(8'h23, 0);
        applyStimulus(8'h2B, 0); applyStimulus(8'h34, 2);
        repeat (3) @(negedge clk);
        checkOutput("s_full_overflow", {31'b0, overflow}, 32'h1);
        checkOutput("s_full_head", {24'b0, ev_code}, 32'h1C);
        checkOutput("s_full_nopop", evlog.size() - base, 32'h0);
        ready_force = 1;
        waitDrain("s_full");
        expq.delete();
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1B, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h23, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h2B, 0, 0, 4'h0));
        checkEvents("s_full", base);

        // Reset abandons a partial E0 F0 sequence
        doReset();
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 1);
        doReset();
        base = evlog.size();
        applyStimulus(8'h75, 2);
        waitDrain("s_reset_mid");
        expq.delete();
        expq.push_back(mkEv(8'h75, 0, 0, 4'h0));
        checkEvents("s_reset_mid", base);

        // Autorepeat and caps lock
        doReset();
        base = evlog.size();
        applyStimulus(8'h1C, 0); applyStimulus(8'h1C, 0); applyStimulus(8'h1C, 0);
        applyStimulus(8'hF0, 0); applyStimulus(8'h1C, 0);
        applyStimulus(8'h58, 0); applyStimulus(8'h58, 2);
        waitDrain("s_repeat");
        expq.delete();
`ifdef KBD_TYPEMATIC_FILTER_EN
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1C, 0, 1, 4'h0));
        expq.push_back(mkEv(8'h58, 0, 0, 4'h8));
`else
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1C, 0, 0, 4'h0));
        expq.push_back(mkEv(8'h1C, 0, 1, 4'h0));
        expq.push_back(mkEv(8'h58, 0, 0, 4'h8));
        expq.push_back(mkEv(8'h58, 0, 0, 4'h8));
`endif
        checkEvents("s_repeat", base);

        // Random byte streams with a random consumer and occasional resets
        doReset();
        rand_ready = 1;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                doReset();
            end else begin
                applyStimulus(pickByte(), ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3)));
            end
        end
        ready = 1'b0;
        rand_ready  = 0;
        ready_force = 1;
        waitDrain("s_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_event_decoder.md
KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

Interface
REQ-001 SHALL have parameter EV_FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter MOD_TRACK, default 1, meaning 1 = track modifiers and 0 = ev_mods tied to 0.
REQ-003 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  reset; it is synchronous and active-high.
REQ-005 SHALL have port ready  in  1  PS/2 receiver has a byte available.
REQ-006 SHALL have port data  in  8  PS/2 byte, valid while ready=1.
REQ-007 SHALL have port nextdata_n  out  1  active-low one-cycle pop strobe to the receiver.
REQ-008 SHALL have port ev_valid  out  1  event available at FIFO head.
REQ-009 SHALL have port ev_ready  in  1  consumer accepts the head event.
REQ-010 SHALL have port ev_code  out  8  scancode of the head event.
REQ-011 SHALL have port ev_ext  out  1  head event carried an E0 prefix.
REQ-012 SHALL have port ev_break  out  1  head event is a release (break).
REQ-013 SHALL have port ev_mods  out  4  {caps, alt, ctrl, shift} state after this event was applied.
REQ-014 SHALL have port overflow  out  1  sticky flag: at least one event was dropped because the FIFO was full.

Function
REQ-015 SHALL capture data on an edge where ready=1 and nextdata_n=1, driving nextdata_n=0 for exactly the next cycle; this gives a maximum of one byte per 2 cycles.
REQ-016 SHALL run a parser FSM with states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen).
REQ-017 SHALL make these IDLE transitions: E0 goes to EXT; F0 goes to BRK; 00, AA, E1, FA, FE or FF is discarded and stays in IDLE; any other byte emits a make event (ext=0) and stays in IDLE.
REQ-018 SHALL make these EXT transitions: F0 goes to EXT_BRK; E0 stays in EXT; any other byte emits a make event (ext=1) and returns to IDLE.
REQ-019 SHALL, in BRK, emit a break event (ext=0) for any byte and return to IDLE; in EXT_BRK, emit a break event (ext=1) and return to IDLE.
REQ-020 SHALL set shift on make of 12/59 and clear it on break of 12/59; clear shift only when neither key is held (held bits tracked per key).
REQ-021 SHALL track ctrl from 14 and E0 14, and alt from 11 and E0 11, each using per-key held bits.
REQ-022 SHALL toggle caps on a make of 58 only when 58 is not already held.
REQ-023 SHALL enqueue modifier keys as normal events, with ev_mods reflecting the post-update state.
REQ-024 SHALL write the event to the FIFO on the edge that captures its final byte; ev_valid rises the following cycle when the FIFO was empty.
REQ-025 SHALL pop the head event on an edge where ev_valid=1 and ev_ready=1; ev_* stay stable while ev_valid=1 and ev_ready=0.
REQ-026 SHALL drop a new event when the FIFO is full with no pop on that edge, and set overflow=1.
REQ-027 SHALL perform both a push and a pop when they coincide on a full FIFO, with no drop and the count unchanged.
REQ-028 SHALL wrap the FIFO pointers modulo EV_FIFO_DEPTH and hold a count of width $clog2(EV_FIFO_DEPTH)+1.

Reset
REQ-029 SHALL, on reset=1, set: FSM=IDLE, nextdata_n=1, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_mods=0, overflow=0, FIFO empty, all held bits cleared.
REQ-030 SHALL abandon a partial sequence (E0 or F0 received) when reset is asserted mid-sequence, with no event emitted.
REQ-031 SHALL let reset take priority over a simultaneous capture or pop.

Configuration
REQ-032 SHALL, with KBD_TYPEMATIC_FILTER_EN defined, store the last make {ext, code}; a repeated make equal to it is discarded (no event, no caps toggle), and a break of that key or any other make clears or replaces the stored value.
REQ-033 SHALL, without KBD_TYPEMATIC_FILTER_EN, enqueue every make, including autorepeats.

Structure
REQ-034 SHALL place the parser state enum, prefix constants (E0, F0), modifier scancode constants and the event struct {code, ext, brk, mods} in the shared package kbd_pkg.
REQ-035 SHALL implement the FIFO as the sub-module kbd_event_fifo, parametrised by depth and width.

Verification
REQ-036 SHALL cover: bytes 1C, then F0 1C -> events {1C, make, mods 0} then {1C, break, mods 0}.
REQ-037 SHALL cover: 12, 1C, F0 12 -> {12, make, shift=1}, {1C, make, shift=1}, {12, break, shift=0}.
REQ-038 SHALL cover: E0 75, then E0 F0 75 -> {75, ext=1, make} then {75, ext=1, break}.
REQ-039 SHALL cover: ev_ready=0 with 5 makes and EV_FIFO_DEPTH=4 -> 4 events held and overflow=1; then ev_ready=1 drains them in order.
REQ-040 SHALL cover: reset asserted after E0 F0, then byte 75 -> a make event {75, ext=0}.
REQ-041 SHALL cover: with KBD_TYPEMATIC_FILTER_EN, 1C 1C 1C F0 1C -> only 2 events; and 58 58 -> caps toggles once.
